// File: rtl/serial_frame_pkg.sv
// Shared definitions for the framed PISO serializer: FSM state encoding and line levels.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } frame_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: down-counter reloaded on every state entry, flags the last clk of a bit.
module serial_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_bit_end,
    output logic o_bit_end_next
);

    generate
        if (BIT_CYCLES == 1) begin : g_single
            logic w_unused_ok;
            assign w_unused_ok    = ^{clk, rst_n, i_restart};
            assign o_bit_end      = 1'b1;
            assign o_bit_end_next = 1'b1;
        end else begin : g_count
            localparam int CW = $clog2(BIT_CYCLES);
            localparam logic [CW-1:0] LOAD_VAL = CW'(BIT_CYCLES - 1);

            logic [CW-1:0] r_cnt;

            // Count down through the bit period; a restart reloads the full period.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (i_restart) begin
                    r_cnt <= LOAD_VAL;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end

            assign o_bit_end      = (r_cnt == '0);
            // Lets the parent register a pulse that lines up with the final clk of a bit.
            assign o_bit_end_next = i_restart ? 1'b0 : (r_cnt <= CW'(1));
        end
    endgenerate

endmodule

// File: rtl/piso_frame_serializer.sv
// Framed parallel-in/serial-out transmitter: one-word hold buffer, shift register and bit FSM.
module piso_frame_serializer
    import serial_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int IW = $clog2(DATA_WIDTH + 1);

    frame_state_e          r_state;
    frame_state_e          w_state_nxt;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [IW-1:0]         r_bit_idx;
    logic                  r_hold_full;
    logic                  r_parity;
    logic                  r_serial;
    logic                  r_frame_done;
    logic                  r_busy;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_last_data;
    logic                  w_bit_end;
    logic                  w_bit_end_next;
    logic                  w_restart;
    logic                  w_serial_nxt;
    logic                  w_hold_full_nxt;
    logic                  w_frame_done_nxt;
    logic                  w_busy_nxt;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d);
        return (PARITY_ODD != 0) ? ~^d : ^d;
    endfunction

    assign in_ready    = ~r_hold_full;
    assign w_accept    = in_valid & ~r_hold_full;
    // Load happens from IDLE or straight out of a finished stop bit, giving back-to-back frames.
    assign w_load      = r_hold_full & ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));
    assign w_last_data = (r_bit_idx == IW'(DATA_WIDTH - 1));
    assign w_shift_nxt = r_shift >> 1;

    assign serial_out  = r_serial;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;

    serial_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_restart      (w_restart),
        .o_bit_end      (w_bit_end),
        .o_bit_end_next (w_bit_end_next)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode; every non-IDLE state advances only at the end of its bit period.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = r_hold_full ? START : IDLE;
            START:   w_state_nxt = w_bit_end ? DATA : START;
            DATA: begin
                if (w_bit_end && w_last_data) begin
                    w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                end else begin
                    w_state_nxt = DATA;
                end
            end
            PARITY:  w_state_nxt = w_bit_end ? STOP : PARITY;
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = r_hold_full ? START : IDLE;
                end else begin
                    w_state_nxt = STOP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM output decode: next line level, timer restart and next values of the registered flags.
    always_comb begin
        w_serial_nxt = r_serial;
        if (w_load) begin
            w_serial_nxt = START_BIT;
        end else if ((r_state != IDLE) && w_bit_end) begin
            case (w_state_nxt)
                DATA:    w_serial_nxt = (r_state == START) ? r_shift[0] : w_shift_nxt[0];
                PARITY:  w_serial_nxt = r_parity;
                STOP:    w_serial_nxt = STOP_BIT;
                IDLE:    w_serial_nxt = IDLE_LEVEL;
                default: w_serial_nxt = r_serial;
            endcase
        end else begin
            w_serial_nxt = r_serial;
        end

        w_restart = (w_state_nxt != IDLE) & ((r_state == IDLE) | w_bit_end);

        if (w_accept) begin
            w_hold_full_nxt = 1'b1;
        end else if (w_load) begin
            w_hold_full_nxt = 1'b0;
        end else begin
            w_hold_full_nxt = r_hold_full;
        end

        w_frame_done_nxt = (w_state_nxt == STOP) & w_bit_end_next;
        w_busy_nxt       = (w_state_nxt != IDLE) | w_hold_full_nxt;
    end

    // Datapath: hold buffer, shift register, bit index, captured parity and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_parity     <= 1'b0;
            r_serial     <= IDLE_LEVEL;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold <= in_data;
            end
            if (w_load) begin
                r_shift   <= r_hold;
                r_bit_idx <= '0;
                r_parity  <= calc_parity(r_hold);
            end else if ((r_state == DATA) && w_bit_end) begin
                r_shift   <= w_shift_nxt;
                r_bit_idx <= r_bit_idx + IW'(1);
            end
            r_hold_full  <= w_hold_full_nxt;
            r_serial     <= w_serial_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

endmodule
